// File: rtl/stdp_wb_queue.sv
// STDP weight write-back queue sharing one SRAM port with inference reads.
// Optional STDP_WB_STATS_EN builds the drop counter and high-water mark.
module stdp_wb_queue #(
    parameter int F          = 48,
    parameter int N          = 96,
    parameter int DEPTH      = 8,
    parameter int STARVE_MAX = 16,
    localparam int AW        = $clog2(F * N),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_we,
    input  logic [AW-1:0] in_addr,
    input  logic [15:0]   in_wdata,
    input  logic          inf_re,
    input  logic [AW-1:0] inf_addr,
    output logic          inf_stall,
    input  logic          flush_req,
    output logic          flush_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic [CW-1:0] q_count,
    output logic [15:0]   drop_cnt,
    output logic [CW-1:0] q_hwm
);

    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {NORMAL, FORCE, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] addr_q [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_inc;
    logic          empty;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          rd_cyc;

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        push       = !rst && in_we && !full;
        drop       = !rst && in_we && full;
        // Any non-NORMAL state owns the port for write-back.
        pop        = !rst && !empty && (state != NORMAL || !inf_re);
        rd_cyc     = !rst && state == NORMAL && inf_re;
        count_nxt  = count + CW'(push) - CW'(pop);
        starve_inc = starve + SW'(1);
        inf_stall  = !rst && state != NORMAL && inf_re;
        flush_done = !rst && state == DRAIN && empty;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q[rd_ptr];
            mem_wdata = data_q[rd_ptr];
        end else if (rd_cyc) begin
            mem_en   = 1'b1;
            mem_addr = inf_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NORMAL;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            if (pop || empty || state != NORMAL) starve <= '0;
            else if (inf_re) starve <= starve_inc;
            unique case (state)
                NORMAL: begin
                    if (flush_req) state <= DRAIN;
                    else if (!empty && inf_re && starve_inc == SW'(STARVE_MAX))
                        state <= FORCE;
                end
                FORCE: state <= flush_req ? DRAIN : NORMAL;
                DRAIN: if (empty) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    assign q_count = count;

`ifdef STDP_WB_STATS_EN
    logic [15:0]   drop_q;
    logic [CW-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            hwm_q  <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (count_nxt > hwm_q) hwm_q <= count_nxt;
        end
    end

    assign drop_cnt = drop_q;
    assign q_hwm    = hwm_q;
`else
    assign drop_cnt = '0;
    assign q_hwm    = '0;
`endif

endmodule
